// File: rtl/mem_arbiter_if.sv
// One master's request/response port into the memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned AWIDTH = 14,
  parameter int unsigned DWIDTH = 32
) ();
  localparam int unsigned WEW = DWIDTH / 8;

  logic              req;
  logic              lock;
  logic [WEW-1:0]    we;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous memory.
// Zero-latency grant, round-robin on contention, with a bounded lock burst
// for the last-granted master. Read data returns one cycle after the grant.
module mem_arbiter #(
  parameter int unsigned AWIDTH    = 14,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned BURST_MAX = 8,
  localparam int unsigned WEW      = DWIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic              mem_en,
  output logic [WEW-1:0]    mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  owner_e        owner_q;
  logic          lock_q;     // owner had lock high on its last grant
  logic [CW-1:0] burst_q;
  logic          rvalid0_q;
  logic          rvalid1_q;

  logic          gnt0_c;
  logic          gnt1_c;
  logic          any_gnt_c;
  logic          keep_c;
  logic          owner_req_c;
  logic          lock_c;
  owner_e        sel_c;

  assign keep_c      = lock_q && (burst_q < CW'(BURST_MAX));
  assign owner_req_c = (owner_q == OWN_M0) ? m0.req : m1.req;
  assign any_gnt_c   = gnt0_c | gnt1_c;
  assign sel_c       = gnt1_c ? OWN_M1 : OWN_M0;
  assign lock_c      = gnt1_c ? m1.lock : m0.lock;

  // Grant decision: sole requester wins; on contention the owner keeps it
  // only while its lock burst has budget, otherwise the other side wins.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst) begin
      case ({m1.req, m0.req})
        2'b01:   gnt0_c = 1'b1;
        2'b10:   gnt1_c = 1'b1;
        2'b11: begin
          if ((owner_q == OWN_M0) == keep_c) gnt0_c = 1'b1;
          else                               gnt1_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Memory port follows the granted master; write enables forced low when idle.
  always_comb begin
    mem_en    = any_gnt_c;
    mem_we    = '0;
    mem_addr  = m0.addr;
    mem_wdata = m0.wdata;
    if (gnt1_c) begin
      mem_we    = m1.we;
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
    end else if (gnt0_c) begin
      mem_we    = m0.we;
    end
  end

  // Ownership, lock burst tracking and one-cycle read-valid pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_M1;
      lock_q    <= 1'b0;
      burst_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= gnt0_c && (m0.we == '0);
      rvalid1_q <= gnt1_c && (m1.we == '0);
      if (any_gnt_c) begin
        owner_q <= sel_c;
        lock_q  <= lock_c;
        if ((sel_c == owner_q) && lock_c) begin
          if (burst_q < CW'(BURST_MAX)) burst_q <= burst_q + CW'(1);
        end else begin
          burst_q <= '0;
        end
      end else if (!owner_req_c) begin
        // owner walked away: its lock no longer counts
        lock_q <= 1'b0;
      end
    end
  end

  assign m0.gnt    = gnt0_c;
  assign m1.gnt    = gnt1_c;
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = mem_rdata;
  assign m1.rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a behavioural memory.
module tb_mem_arbiter;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 32;
  localparam int unsigned BM    = 8;
  localparam int unsigned DEPTH = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) m0_if ();
  mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) m1_if ();

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [DW-1:0] fval(input logic [AW-1:0] a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Synchronous single-port memory; reloaded with a known pattern during reset.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= fval(14'(i));
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic l, input logic [3:0] w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_if.req = r; m0_if.lock = l; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d;
  endtask

  task automatic set1(input logic r, input logic l, input logic [3:0] w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_if.req = r; m1_if.lock = l; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d;
  endtask

  task automatic init_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = fval(14'(i));
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [3:0] w, input logic [DW-1:0] d);
    for (int b = 0; b < 4; b++)
      if (w[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  logic          r0, r1, l0, l1;
  logic [3:0]    w0, w1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          pend0, pend1, npend0, npend1;
  logic [DW-1:0] pdat0, pdat1, npdat0, npdat1;
  logic          prev_g0;
  logic [AW-1:0] prev_a;

  initial begin
    init_ref();
    // reset held with both masters requesting: everything must stay quiet
    set0(1'b1, 1'b0, 4'h0, 14'h10, 32'h0);
    set1(1'b1, 1'b0, 4'h0, 14'h20, 32'h0);
    repeat (3) tick();
    chk("rst_gnt0",   32'(m0_if.gnt),    32'd0);
    chk("rst_gnt1",   32'(m1_if.gnt),    32'd0);
    chk("rst_mem_en", 32'(mem_en),       32'd0);
    chk("rst_mem_we", 32'(mem_we),       32'd0);
    chk("rst_rv0",    32'(m0_if.rvalid), 32'd0);
    chk("rst_rv1",    32'(m1_if.rvalid), 32'd0);

    // release: first tie goes to m0
    rst = 1'b1;
    #1;
    chk("first_gnt0", 32'(m0_if.gnt), 32'd1);
    chk("first_gnt1", 32'(m1_if.gnt), 32'd0);
    chk("first_addr", 32'(mem_addr),  32'h10);
    chk("first_en",   32'(mem_en),    32'd1);
    chk("first_we",   32'(mem_we),    32'd0);
    tick();
    chk("second_gnt1", 32'(m1_if.gnt),    32'd1);
    chk("second_gnt0", 32'(m0_if.gnt),    32'd0);
    chk("second_addr", 32'(mem_addr),     32'h20);
    chk("second_rv0",  32'(m0_if.rvalid), 32'd1);
    chk("second_rd0",  m0_if.rdata,       32'hA500_0010);
    chk("second_rv1",  32'(m1_if.rvalid), 32'd0);
    tick();
    set0(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    set1(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    #1;
    chk("third_rv1", 32'(m1_if.rvalid), 32'd1);
    chk("third_rd1", m1_if.rdata,       32'hA500_0020);
    chk("third_rv0", 32'(m0_if.rvalid), 32'd0);
    chk("third_en",  32'(mem_en),       32'd0);

    // continuous contention without lock alternates, rvalid follows one cycle later
    prev_g0 = 1'b0;
    prev_a  = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      set0(1'b1, 1'b0, 4'h0, 14'(32'h30 + k), 32'h0);
      set1(1'b1, 1'b0, 4'h0, 14'(32'h40 + k), 32'h0);
      #1;
      chk($sformatf("alt%0d_g0", k), 32'(m0_if.gnt), 32'((k % 2) == 0));
      chk($sformatf("alt%0d_g1", k), 32'(m1_if.gnt), 32'((k % 2) == 1));
      if (k > 0) begin
        chk($sformatf("alt%0d_rv0", k), 32'(m0_if.rvalid), 32'(prev_g0));
        chk($sformatf("alt%0d_rv1", k), 32'(m1_if.rvalid), 32'(!prev_g0));
        chk($sformatf("alt%0d_rd", k), prev_g0 ? m0_if.rdata : m1_if.rdata, fval(prev_a));
      end
      prev_g0 = ((k % 2) == 0);
      prev_a  = prev_g0 ? 14'(32'h30 + k) : 14'(32'h40 + k);
    end

    // make m0 owner, then m1 takes over with lock: 1 + BURST_MAX grants, then m0
    tick();
    set0(1'b1, 1'b0, 4'h0, 14'h50, 32'h0);
    set1(1'b0, 1'b0, 4'h0, 14'h60, 32'h0);
    #1;
    chk("pre_burst_g0", 32'(m0_if.gnt), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      set0(1'b1, 1'b1, 4'h0, 14'h50, 32'h0);
      set1(1'b1, 1'b1, 4'h0, 14'h60, 32'h0);
      #1;
      chk($sformatf("burst%0d_g1", k), 32'(m1_if.gnt), 32'(k < 9));
      chk($sformatf("burst%0d_g0", k), 32'(m0_if.gnt), 32'(k >= 9));
    end

    // locked owner m0 drops req for a cycle: lock priority is gone afterwards
    tick();
    set0(1'b0, 1'b1, 4'h0, 14'h50, 32'h0);
    set1(1'b0, 1'b0, 4'h0, 14'h60, 32'h0);
    #1;
    chk("drop_idle_en", 32'(mem_en), 32'd0);
    tick();
    set0(1'b1, 1'b1, 4'h0, 14'h50, 32'h0);
    set1(1'b1, 1'b0, 4'h0, 14'h60, 32'h0);
    #1;
    chk("drop_g1", 32'(m1_if.gnt), 32'd1);
    chk("drop_g0", 32'(m0_if.gnt), 32'd0);

    // partial write at the top address, no rvalid; read-back merges bytes
    tick();
    set0(1'b1, 1'b0, 4'b0011, 14'h3FFF, 32'hDEAD_BEEF);
    set1(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    #1;
    chk("wr_g0",    32'(m0_if.gnt), 32'd1);
    chk("wr_we",    32'(mem_we),    32'h3);
    chk("wr_addr",  32'(mem_addr),  32'h3FFF);
    chk("wr_wdata", mem_wdata,      32'hDEAD_BEEF);
    tick();
    set0(1'b1, 1'b0, 4'h0, 14'h3FFF, 32'h0);
    #1;
    chk("wr_no_rv0", 32'(m0_if.rvalid), 32'd0);
    chk("rb_we",     32'(mem_we),       32'd0);
    tick();
    set0(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    #1;
    chk("rb_rv0", 32'(m0_if.rvalid), 32'd1);
    chk("rb_rd0", m0_if.rdata,       32'hA500_BEEF);

    // reset lands while a read is granted: its rvalid never appears
    tick();
    set0(1'b1, 1'b0, 4'h0, 14'h10, 32'h0);
    #1;
    chk("inflt_g0", 32'(m0_if.gnt), 32'd1);
    rst = 1'b0;
    #1;
    chk("inflt_rst_g0", 32'(m0_if.gnt), 32'd0);
    chk("inflt_rst_en", 32'(mem_en),    32'd0);
    tick();
    chk("inflt_rv0_rst", 32'(m0_if.rvalid), 32'd0);
    set0(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    rst = 1'b1;
    init_ref();
    tick();
    chk("inflt_rv0_post", 32'(m0_if.rvalid), 32'd0);

    // after reset m1 is owner with an empty burst: sole locked grant counts one
    set1(1'b1, 1'b1, 4'h0, 14'h20, 32'h0);
    #1;
    chk("post_rst_g1", 32'(m1_if.gnt), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      set0(1'b1, 1'b0, 4'h0, 14'h11, 32'h0);
      set1(1'b1, 1'b1, 4'h0, 14'h20, 32'h0);
      #1;
      chk($sformatf("post_rst%0d_g1", k), 32'(m1_if.gnt), 32'(k < 7));
    end

    // drain before random traffic
    tick();
    set0(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    set1(1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    tick();
    pend0 = 1'b0; pend1 = 1'b0; pdat0 = '0; pdat1 = '0;

    for (int c = 0; c < 3000; c++) begin
      tick();
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      l0 = 1'($urandom_range(0, 1));
      l1 = 1'($urandom_range(0, 1));
      w0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      w1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      a0 = 14'($urandom_range(0, 31));
      a1 = 14'($urandom_range(0, 31));
      d0 = $urandom;
      d1 = $urandom;
      set0(r0, l0, w0, a0, d0);
      set1(r1, l1, w1, a1, d1);
      #1;
      chk("rnd_excl", 32'(m0_if.gnt & m1_if.gnt), 32'd0);
      chk("rnd_work", 32'(m0_if.gnt | m1_if.gnt), 32'(r0 | r1));
      chk("rnd_rv0",  32'(m0_if.rvalid), 32'(pend0));
      chk("rnd_rv1",  32'(m1_if.rvalid), 32'(pend1));
      if (pend0) chk("rnd_rd0", m0_if.rdata, pdat0);
      if (pend1) chk("rnd_rd1", m1_if.rdata, pdat1);
      npend0 = 1'b0; npend1 = 1'b0; npdat0 = '0; npdat1 = '0;
      if (m0_if.gnt) begin
        chk("rnd_addr0", 32'(mem_addr), 32'(a0));
        chk("rnd_we0",   32'(mem_we),   32'(w0));
        if (w0 == 4'h0) begin
          npend0 = 1'b1;
          npdat0 = ref_mem[a0];
        end else begin
          chk("rnd_wd0", mem_wdata, d0);
          ref_write(a0, w0, d0);
        end
      end else if (m1_if.gnt) begin
        chk("rnd_addr1", 32'(mem_addr), 32'(a1));
        chk("rnd_we1",   32'(mem_we),   32'(w1));
        if (w1 == 4'h0) begin
          npend1 = 1'b1;
          npdat1 = ref_mem[a1];
        end else begin
          chk("rnd_wd1", mem_wdata, d1);
          ref_write(a1, w1, d1);
        end
      end
      pend0 = npend0; pend1 = npend1; pdat0 = npdat0; pdat1 = npdat1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AWIDTH, default 14, SHALL be the word-address width (16384-word memory).
REQ-002 Parameter DWIDTH, default 32, SHALL be the data width.
REQ-003 Parameter BURST_MAX, default 8, SHALL be the maximum consecutive locked grants to one master while the other master waits.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 mN_req  input  1  (N=0,1) SHALL be the master N access request.
REQ-007 mN_lock  input  1  SHALL request that master N keep ownership for its next access.
REQ-008 mN_we  input  DWIDTH/8  SHALL be the byte write enables; all-zero means read.
REQ-009 mN_addr  input  AWIDTH  SHALL be the word address.
REQ-010 mN_wdata  input  DWIDTH  SHALL be the write data.
REQ-011 mN_gnt  output  1  SHALL indicate acceptance of master N's access this cycle.
REQ-012 mN_rvalid  output  1  SHALL flag valid read data for master N.
REQ-013 mN_rdata  output  DWIDTH  SHALL carry the read data for master N.
REQ-014 mem_en  output  1, mem_we  output  DWIDTH/8, mem_addr  output  AWIDTH, mem_wdata  output  DWIDTH SHALL drive the single-port synchronous memory.
REQ-015 mem_rdata  input  DWIDTH SHALL be the memory read data, valid one cycle after an enabled read.

Function
REQ-016 At most one of m0_gnt/m1_gnt SHALL be high in any cycle.
REQ-017 Grant SHALL be combinational from current req and registered state (zero-cycle grant latency).
REQ-018 mem_en SHALL equal (m0_gnt | m1_gnt); mem_we/addr/wdata SHALL be the granted master's inputs, and mem_we SHALL be zero when no grant.
REQ-019 A sole requester SHALL be granted.
REQ-020 With both requesting: if the last-granted master (owner) held lock on its previous grant and burst_cnt < BURST_MAX, the owner SHALL be granted; otherwise the non-owner SHALL be granted (round-robin).
REQ-021 owner register SHALL update to the granted master on every grant; it SHALL hold when no grant.
REQ-022 burst_cnt SHALL increment (saturating at BURST_MAX) when the owner is re-granted with lock high, and SHALL reset to 0 when ownership changes or a grant occurs with lock low.
REQ-023 A read grant (we all-zero) SHALL assert that master's rvalid for exactly the next cycle, with mN_rdata = mem_rdata in that cycle.
REQ-024 A write grant SHALL never produce rvalid.
REQ-025 Back-to-back grants SHALL be supported: one access per cycle, full throughput, rvalid pipelined one cycle behind.
REQ-026 mN_rdata SHALL be mem_rdata unconditionally; consumers use rvalid only.
REQ-027 A master dropping req while owner SHALL lose lock priority immediately; the other master is then granted if requesting.
REQ-028 Lock from a non-owner SHALL have no effect on arbitration.

Reset
REQ-029 While rst is low: m0_gnt, m1_gnt, mem_en, mem_we, m0_rvalid, m1_rvalid SHALL be 0.
REQ-030 Reset SHALL set owner = master 1 and burst_cnt = 0, so master 0 wins the first tie.
REQ-031 Reset asserted with a read in flight SHALL cancel the pending rvalid; no rvalid after release for pre-reset grants.

Verification
REQ-032 Reset release, both req read addr 0x10/0x20 same cycle -> m0_gnt=1, mem_addr=0x10; next cycle m1_gnt=1, m0_rvalid=1 with mem_rdata.
REQ-033 Both req continuously, no lock -> grants alternate m0,m1,m0,... one per cycle; each read rvalid exactly one cycle later to its master.
REQ-034 m1 owner, m1_lock=1 held, m0 requesting -> m1 granted 9 consecutive cycles (first + BURST_MAX=8 locked re-grants), then m0 granted.
REQ-035 m0 write we=4'b0011 addr 0x3FFF data 0xDEADBEEF, sole requester -> mem_we=4'b0011, mem_addr=0x3FFF; no m0_rvalid next cycle.
REQ-036 Read granted, rst pulled low same half-cycle before next edge -> m0_rvalid stays 0; after release, owner=1, burst_cnt=0.
REQ-037 Random two-master traffic 3000 cycles against a reference memory model -> every read returns last written data; never both gnt high.
